// File: rtl/int_ctrl_pkg.sv
// Shared encodings for the interrupt controller: trigger modes, FSM states,
// status word layout and the vector address format.
package int_ctrl_pkg;

    localparam int NUM_IRQ     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = 3;

    localparam logic [1:0] TRIG_LVL_HI = 2'b00;
    localparam logic [1:0] TRIG_LVL_LO = 2'b01;
    localparam logic [1:0] TRIG_RISE   = 2'b10;
    localparam logic [1:0] TRIG_FALL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam int STAT_PEND_LSB = 0;
    localparam int STAT_ID_LSB   = 8;
    localparam int STAT_INSVC    = 11;
    localparam int STAT_REQ      = 12;

    function automatic logic [15:0] vec_addr(input logic [7:0] base, input logic [ID_W-1:0] id);
        return {base, 3'b000, id, 2'b00};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: synchroniser chain, previous-value flop, and trigger
// decode. hit_o is the edge event in edge modes or the live condition in level modes.
module irq_sync_edge
    import int_ctrl_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       irq_i,
    input  logic [1:0] trig_i,
    output logic       hit_o,
    output logic       lvl_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              s;

    assign s = sync_q[STAGES-1];

    // prev_q resets low so a line held high through reset yields one rising event
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], irq_i};
            prev_q <= s;
        end
    end

    always_comb begin
        hit_o = 1'b0;
        case (trig_i)
            TRIG_LVL_HI: hit_o = s;
            TRIG_LVL_LO: hit_o = ~s;
            TRIG_RISE:   hit_o = s & ~prev_q;
            TRIG_FALL:   hit_o = ~s & prev_q;
            default:     hit_o = 1'b0;
        endcase
    end

    assign lvl_o = ~trig_i[1];

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: pending capture, fixed priority (line 0 highest),
// IDLE/REQ/SERVICE handshake with the CPU, and a status word for the SFR window.
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  irq_i,
    input  logic [7:0]  ctl_reg_i,
    input  logic [7:0]  mask_reg_i,
    input  logic [15:0] trig_reg_i,
    input  logic [7:0]  vec_base_i,
    input  logic [7:0]  pend_clr_i,
    input  logic        int_ack_i,
    input  logic        reti_i,
    output logic        int_req_o,
    output logic [15:0] int_addr_o,
    output logic [15:0] status_o
);

    logic [NUM_IRQ-1:0] hit;
    logic [NUM_IRQ-1:0] lvl;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] elig;
    logic               cand_vld;
    logic [ID_W-1:0]    cand_id;
    logic               ack_clr;
    state_e             state_q;
    logic [ID_W-1:0]    id_q;
    logic               int_req_q;
    logic               svc_q;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .irq_i   (irq_i[g]),
            .trig_i  (trig_reg_i[2*g+1:2*g]),
            .hit_o   (hit[g]),
            .lvl_o   (lvl[g])
        );
    end

    assign ack_clr = (state_q == ST_REQ) && int_ack_i;

    // A new event wins over any clear landing in the same cycle
    always_comb begin
        pend_d = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (lvl[n]) begin
                pend_d[n] = hit[n];
            end else begin
                pend_d[n] = hit[n] | (pend_q[n] & ~pend_clr_i[n]
                                      & ~(ack_clr && (id_q == n[ID_W-1:0])));
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign elig = pend_q & mask_reg_i & {NUM_IRQ{ctl_reg_i[0]}};

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                cand_vld = 1'b1;
                cand_id  = i[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            int_req_q <= 1'b0;
            svc_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_vld) begin
                        state_q   <= ST_REQ;
                        id_q      <= cand_id;
                        int_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack_i) begin
                        state_q   <= ST_SERVICE;
                        int_req_q <= 1'b0;
                        svc_q     <= 1'b1;
                    end else if (!cand_vld) begin
                        state_q   <= ST_IDLE;
                        int_req_q <= 1'b0;
                    end else begin
                        id_q      <= cand_id;
                    end
                end
                ST_SERVICE: begin
                    if (reti_i) begin
                        state_q <= ST_IDLE;
                        svc_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    int_req_q <= 1'b0;
                    svc_q     <= 1'b0;
                end
            endcase
        end
    end

    assign int_req_o  = int_req_q;
    assign int_addr_o = vec_addr(vec_base_i, id_q);

    always_comb begin
        status_o                                 = '0;
        status_o[STAT_PEND_LSB +: NUM_IRQ]       = pend_q;
        status_o[STAT_ID_LSB +: ID_W]            = id_q;
        status_o[STAT_INSVC]                     = svc_q;
        status_o[STAT_REQ]                       = int_req_q;
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with hand-computed status/request/address values.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic [7:0]  ctl;
    logic [7:0]  mask;
    logic [15:0] trig;
    logic [7:0]  vbase;
    logic [7:0]  pclr;
    logic        ack;
    logic        reti;
    logic        req;
    logic [15:0] addr;
    logic [15:0] status;

    int n_chk = 0;
    int n_bad = 0;

    int_ctrl dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .irq_i      (irq),
        .ctl_reg_i  (ctl),
        .mask_reg_i (mask),
        .trig_reg_i (trig),
        .vec_base_i (vbase),
        .pend_clr_i (pclr),
        .int_ack_i  (ack),
        .reti_i     (reti),
        .int_req_o  (req),
        .int_addr_o (addr),
        .status_o   (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        irq   = 8'h00;
        ctl   = 8'h01;
        mask  = 8'hFF;
        trig  = 16'hAAAA;
        vbase = 8'h12;
        pclr  = 8'h00;
        ack   = 1'b0;
        reti  = 1'b0;
        step(2);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_status", {16'd0, status}, 32'h0000);
        chk("rst_addr", {16'd0, addr}, 32'h1200);
        rst = 1'b0;

        // single rising edge on line 3
        irq = 8'h08;
        step(3);
        chk("l3_pend_e3", {16'd0, status}, 32'h0008);
        chk("l3_noreq_e3", {31'd0, req}, 32'd0);
        tick();
        chk("l3_req_e4", {31'd0, req}, 32'd1);
        chk("l3_addr", {16'd0, addr}, 32'h120C);
        chk("l3_status_req", {16'd0, status}, 32'h1308);
        irq = 8'h00;
        pulse_ack();
        chk("l3_service", {16'd0, status}, 32'h0B00);
        pulse_reti();
        chk("l3_reti_idle", {16'd0, status}, 32'h0300);
        tick();

        // lines 1 and 5 together: line 1 first, then 5
        irq = 8'h22;
        step(4);
        chk("dual_req", {31'd0, req}, 32'd1);
        chk("dual_addr1", {16'd0, addr}, 32'h1204);
        chk("dual_status", {16'd0, status}, 32'h1122);
        irq = 8'h00;
        pulse_ack();
        chk("dual_svc1", {16'd0, status}, 32'h0920);
        pulse_reti();
        chk("dual_reti1", {16'd0, status}, 32'h0120);
        tick();
        chk("dual_req5", {31'd0, req}, 32'd1);
        chk("dual_addr5", {16'd0, addr}, 32'h1214);
        pulse_ack();
        pulse_reti();
        chk("dual_reti5", {16'd0, status}, 32'h0500);

        // level-high on line 2, withdrawn before ack
        trig = 16'hAA8A;
        irq  = 8'h04;
        step(4);
        chk("lvl_req", {31'd0, req}, 32'd1);
        chk("lvl_addr", {16'd0, addr}, 32'h1208);
        irq = 8'h00;
        step(3);
        chk("lvl_pend_drop", {16'd0, status}, 32'h1200);
        tick();
        chk("lvl_idle", {16'd0, status}, 32'h0200);
        trig = 16'hAAAA;

        // masked line still pends; unmasking requests next edge
        mask = 8'h00;
        irq  = 8'h01;
        step(4);
        chk("mask_pend", {16'd0, status}, 32'h0201);
        chk("mask_noreq", {31'd0, req}, 32'd0);
        mask = 8'h01;
        tick();
        chk("unmask_req", {31'd0, req}, 32'd1);
        chk("unmask_addr", {16'd0, addr}, 32'h1200);
        irq = 8'h00;
        step(3);
        irq = 8'h01;
        step(2);
        pclr = 8'h01;
        tick();
        pclr = 8'h00;
        chk("set_beats_clr", {16'd0, status}, 32'h1001);
        pclr = 8'h01;
        tick();
        pclr = 8'h00;
        chk("clr_only", {16'd0, status}, 32'h1000);
        tick();
        chk("clr_to_idle", {16'd0, status}, 32'h0000);
        mask = 8'hFF;

        // event during service waits for reti
        irq = 8'h00;
        step(2);
        irq = 8'h10;
        step(4);
        chk("svc_addr4", {16'd0, addr}, 32'h1210);
        pulse_ack();
        chk("svc_enter", {16'd0, status}, 32'h0C00);
        irq = 8'h11;
        step(4);
        chk("svc_pend0", {16'd0, status}, 32'h0C01);
        chk("svc_noreq", {31'd0, req}, 32'd0);
        pulse_reti();
        chk("svc_reti", {16'd0, status}, 32'h0401);
        tick();
        chk("svc_reissue", {16'd0, status}, 32'h1001);
        chk("svc_reissue_addr", {16'd0, addr}, 32'h1200);

        // reset in REQ with pending 0x28, lines held high through it
        pulse_ack();
        irq = 8'h00;
        step(3);
        irq = 8'h28;
        step(4);
        chk("pre_rst_svc", {16'd0, status}, 32'h0828);
        pulse_reti();
        tick();
        chk("pre_rst_req", {16'd0, status}, 32'h1328);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_status", {16'd0, status}, 32'h0000);
        chk("mid_rst_addr", {16'd0, addr}, 32'h1200);
        rst = 1'b0;
        step(3);
        chk("post_rst_pend", {16'd0, status}, 32'h0028);
        tick();
        chk("post_rst_req", {31'd0, req}, 32'd1);
        chk("post_rst_addr", {16'd0, addr}, 32'h120C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
